seg7_frame_capture: RTL

- Reads a multiplexed 7-segment display bus: segment pattern plus one-hot digit select. This is the same bus our segment decoders drive.
- Recovers the BCD digit, decimal point and pattern-error flag per digit position.
- Presents one complete multi-digit frame at a time on a valid/ready output.
- Used as a display-bus monitor and loopback checker beside the segment-drive path.

---
 rtl/seg7_frame_capture.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg7_frame_capture.sv
// Multiplexed 7-segment bus monitor: captures each digit once it has dwelt long enough and
// presents whole frames on valid/ready. Define SEG7_ACTIVE_LOW_EN for a common-anode bus.
module seg7_frame_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     err,
  output logic                  overflow
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  localparam logic [3:0] SAT = 4'(STABLE_CYCLES);
  // Counter value seen on the cycle before the dwell reaches STABLE_CYCLES samples.
  localparam logic [3:0] PRE = 4'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);

  logic [7:0]           seg_s;
  logic [DIGITS-1:0]    sel_s;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_s = ~seg_in;
  assign sel_s = ~dig_sel;
`else
  assign seg_s = seg_in;
  assign sel_s = dig_sel;
`endif

  logic [7:0]           prev_seg_reg;
  logic [DIGITS-1:0]    prev_sel_reg;
  logic [3:0]           cnt_reg, cnt_next;
  logic                 one_hot, same, capture;
  logic [DIGITS-1:0]    cap_sel;
  logic [4:0]           dec;

  logic [DIGITS-1:0]    mask_reg, mask_acc, mask_next;
  logic                 complete;

  logic [4*DIGITS-1:0]  slot_code_reg, slot_code_next;
  logic [DIGITS-1:0]    slot_dp_reg, slot_dp_next;
  logic [DIGITS-1:0]    slot_err_reg, slot_err_next;

  state_t               state_reg, state_next;
  logic                 load, drop;

  function automatic logic [4:0] decode(input logic [6:0] p);
    // Result is {err, code}.
    case (p)
      7'b1111110: return 5'h00;
      7'b0110000: return 5'h01;
      7'b1101101: return 5'h02;
      7'b1111001: return 5'h03;
      7'b0110011: return 5'h04;
      7'b1011011: return 5'h05;
      7'b1011111: return 5'h06;
      7'b1110000: return 5'h07;
      7'b1111111: return 5'h08;
      7'b1111011: return 5'h09;
      7'b0000000: return 5'h0B;
      default:    return 5'h1F;
    endcase
  endfunction

  assign one_hot = (sel_s != '0) && ((sel_s & (sel_s - DIGITS'(1))) == '0);
  assign same    = (sel_s == prev_sel_reg) && (seg_s == prev_seg_reg);
  assign capture = one_hot && ((STABLE_CYCLES == 1) || (same && (cnt_reg == PRE)));
  assign cap_sel = capture ? sel_s : '0;
  assign dec     = decode(seg_s[7:1]);

  always_comb begin
    cnt_next = 4'd0;
    if (same && one_hot) begin
      cnt_next = (cnt_reg >= SAT) ? SAT : cnt_reg + 4'd1;
    end
  end

  assign mask_acc  = mask_reg | cap_sel;
  assign complete  = &mask_acc;
  assign mask_next = complete ? '0 : mask_acc;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
      assign slot_code_next[4*gi +: 4] = cap_sel[gi] ? dec[3:0] : slot_code_reg[4*gi +: 4];
      assign slot_dp_next[gi]          = cap_sel[gi] ? seg_s[0] : slot_dp_reg[gi];
      assign slot_err_next[gi]         = cap_sel[gi] ? dec[4]   : slot_err_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (complete) begin
          load       = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (complete) begin
          // A frame finishing during a handshake replaces the outgoing one seamlessly.
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign out_valid = (state_reg == PRESENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg_reg  <= '0;
      prev_sel_reg  <= '0;
      cnt_reg       <= '0;
      mask_reg      <= '0;
      slot_code_reg <= '0;
      slot_dp_reg   <= '0;
      slot_err_reg  <= '0;
      state_reg     <= COLLECT;
      digits        <= '0;
      dp            <= '0;
      err           <= '0;
      overflow      <= 1'b0;
    end else begin
      prev_seg_reg  <= seg_s;
      prev_sel_reg  <= sel_s;
      cnt_reg       <= cnt_next;
      mask_reg      <= mask_next;
      slot_code_reg <= slot_code_next;
      slot_dp_reg   <= slot_dp_next;
      slot_err_reg  <= slot_err_next;
      state_reg     <= state_next;
      if (load) begin
        digits <= slot_code_next;
        dp     <= slot_dp_next;
        err    <= slot_err_next;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
